// File: rtl/neopx_pkg.sv
// NeoPixel serializer shared types and default timing.
// Defaults assume a 48 MHz clock.
package neopx_pkg;

  typedef enum logic [2:0] {
    ST_READY,
    ST_HIGH,
    ST_LOW,
    ST_GAP,
    ST_LATCH
  } state_e;

  localparam int T0H_DEF  = 19;
  localparam int T1H_DEF  = 38;
  localparam int TBIT_DEF = 60;
  localparam int GAP_DEF  = 96;
  localparam int TRST_DEF = 14400;

  localparam int PIX_W = 24;
  localparam int G_HI  = 23;
  localparam int G_LO  = 16;
  localparam int R_HI  = 15;
  localparam int R_LO  = 8;
  localparam int B_HI  = 7;
  localparam int B_LO  = 0;

  function automatic int cnt_width(
    input int a,
    input int b
  );
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/neopx_bit_timer.sv
// Free-running up counter, cleared on demand.
// done_o flags the last cycle of a lim_i-long interval.
module neopx_bit_timer #(
  parameter int CW = 14
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          clr_i,
  input  logic [CW-1:0] lim_i,
  output logic          done_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i) cnt_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == lim_i - CW'(1));

endmodule

// File: rtl/neopx_ws2812_tx.sv
// WS2812 single-wire NRZ serializer, GRB MSB first.
// Frames end with a latch low period and a done pulse.
module neopx_ws2812_tx
  import neopx_pkg::*;
#(
  parameter int T0H_CYC     = T0H_DEF,
  parameter int T1H_CYC     = T1H_DEF,
  parameter int TBIT_CYC    = TBIT_DEF,
  parameter int GAP_MAX_CYC = GAP_DEF,
  parameter int TRESET_CYC  = TRST_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] s_axis_data,
  input  logic        s_axis_valid,
  output logic        s_axis_ready,
  output logic        o_dout,
  output logic        o_busy,
  output logic        o_frame_done
);

  localparam int CW = cnt_width(TRESET_CYC, GAP_MAX_CYC);

  state_e           state_q, state_d;
  logic [PIX_W-1:0] shreg_q, shreg_d;
  logic [4:0]       idx_q, idx_d;
  logic             ready_q, busy_q;
  logic             done_q, done_d;
  logic             hi_q, dout_q;
  logic             clr, tdone, accept;
  logic [CW-1:0]    lim, hi_lim, lo_lim;
  logic             unused_hi;

  assign unused_hi = ^s_axis_data[31:PIX_W];
  assign accept    = s_axis_valid && ready_q;
  assign hi_lim    = shreg_q[PIX_W-1] ? CW'(T1H_CYC)
                                      : CW'(T0H_CYC);
  assign lo_lim    = CW'(TBIT_CYC) - hi_lim;

  neopx_bit_timer #(
    .CW(CW)
  ) u_timer (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .clr_i  (clr),
    .lim_i  (lim),
    .done_o (tdone)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    clr     = 1'b0;
    done_d  = 1'b0;
    lim     = '0;
    unique case (state_q)
      ST_READY: begin
        clr = 1'b1;
        if (accept) begin
          state_d = ST_HIGH;
          shreg_d = s_axis_data[G_HI:B_LO];
          idx_d   = 5'(PIX_W - 1);
        end
      end
      ST_HIGH: begin
        lim = hi_lim;
        if (tdone) begin
          state_d = ST_LOW;
          clr     = 1'b1;
        end
      end
      ST_LOW: begin
        lim = lo_lim;
        if (tdone) begin
          clr = 1'b1;
          if (idx_q != '0) begin
            state_d = ST_HIGH;
            shreg_d = {shreg_q[PIX_W-2:0], 1'b0};
            idx_d   = idx_q - 5'd1;
          end else begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        lim = CW'(GAP_MAX_CYC);
        // A word arriving on the expiry cycle keeps the frame open
        if (accept) begin
          state_d = ST_HIGH;
          shreg_d = s_axis_data[G_HI:B_LO];
          idx_d   = 5'(PIX_W - 1);
          clr     = 1'b1;
        end else if (tdone) begin
          state_d = ST_LATCH;
          clr     = 1'b1;
        end
      end
      ST_LATCH: begin
        lim = CW'(TRESET_CYC);
        if (tdone) begin
          state_d = ST_READY;
          clr     = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_LATCH;
        clr     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_LATCH;
      shreg_q <= '0;
      idx_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      hi_q    <= 1'b0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      ready_q <= (state_d == ST_READY)
              || (state_d == ST_GAP);
      busy_q  <= (state_d != ST_READY);
      done_q  <= done_d;
      hi_q    <= (state_q == ST_HIGH);
      dout_q  <= hi_q;
    end
  end

  assign s_axis_ready = ready_q;
  assign o_busy       = busy_q;
  assign o_frame_done = done_q;
  assign o_dout       = dout_q;

endmodule

// File: tb/tb_neopx_ws2812_tx.sv
// Scoreboard bench for neopx_ws2812_tx.
// A negedge monitor decodes o_dout into bits and pops expectations.
module tb_neopx_ws2812_tx;

  localparam int T0H  = 19;
  localparam int T1H  = 38;
  localparam int TBIT = 60;
  localparam int TRST = 14400;

  logic        clk;
  logic        rst_n;
  logic [31:0] s_axis_data;
  logic        s_axis_valid;
  logic        s_axis_ready;
  logic        o_dout;
  logic        o_busy;
  logic        o_frame_done;

  typedef struct packed {
    logic v;
    logic first;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_done   = 0;

  neopx_ws2812_tx dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .s_axis_data (s_axis_data),
    .s_axis_valid(s_axis_valid),
    .s_axis_ready(s_axis_ready),
    .o_dout      (o_dout),
    .o_busy      (o_busy),
    .o_frame_done(o_frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input int got,
                     input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               nm, got, exp);
    end
  endtask

  // Monitor: measure high/low runs, decode bits
  int  hi_c, lo_c, last_hi;
  bit  prev, have_bit;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hi_c = 0;
      lo_c = 0;
      prev = 1'b0;
      have_bit = 1'b0;
    end else begin
      if (o_frame_done) n_done++;
      if (o_dout) begin
        if (!prev) begin
          if (have_bit && exp_q.size() > 0
              && !exp_q[0].first)
            chk("bit_period", last_hi + lo_c, TBIT);
          hi_c = 0;
        end
        hi_c++;
      end else begin
        if (prev) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_bit_hi", hi_c, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("bit_high_time", hi_c,
                e.v ? T1H : T0H);
          end
          last_hi = hi_c;
          have_bit = 1'b1;
          lo_c = 0;
        end
        lo_c++;
      end
      prev = o_dout;
    end
  end

  task automatic push_word(input logic [31:0] d);
    for (int i = 23; i >= 0; i--)
      exp_q.push_back('{v: d[i], first: (i == 23)});
  endtask

  // Call at #1 after an edge with ready known high
  task automatic send_word(input logic [31:0] d);
    push_word(d);
    s_axis_data  = d;
    s_axis_valid = 1'b1;
    @(posedge clk);
    #1;
    s_axis_valid = 1'b0;
  endtask

  task automatic wait_ready(input int maxc);
    int n = 0;
    while (!s_axis_ready && n < maxc) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!s_axis_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic wait_done(input  int maxc,
                           output int n,
                           output bit saw_rdy,
                           output bit pbusy);
    n = 0;
    saw_rdy = 1'b0;
    pbusy = 1'b0;
    do begin
      pbusy = o_busy;
      @(posedge clk);
      #1;
      n++;
      if (!o_frame_done && s_axis_ready)
        saw_rdy = 1'b1;
    end while (!o_frame_done && n < maxc);
    if (!o_frame_done) chk("done_timeout", 0, 1);
  endtask

  logic [31:0] words [8] = '{
    32'h0000_00FF, 32'h0000_AA55,
    32'hAB12_3456, 32'h00F0_F0F0,
    32'h000F_0F0F, 32'h0080_0001,
    32'h007F_FFFE, 32'h00FF_0000
  };

  initial begin
    int n, d0;
    bit sr, pb;
    rst_n = 1'b0;
    s_axis_valid = 1'b0;
    s_axis_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", s_axis_ready, 0);
    chk("rst_busy", o_busy, 1);
    chk("rst_dout", o_dout, 0);
    chk("rst_done", o_frame_done, 0);
    rst_n = 1'b1;

    // Power-up latch
    wait_done(20000, n, sr, pb);
    chk("init_latch_len", n, TRST);
    chk("init_early_ready", sr, 0);
    chk("init_ready", s_axis_ready, 1);
    chk("init_busy", o_busy, 0);
    chk("init_busy_before", pb, 1);
    @(posedge clk);
    #1;
    chk("done_one_cycle", o_frame_done, 0);

    // Single word with ignored valid pulses
    d0 = n_done;
    send_word(32'h0080_0001);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
      s_axis_valid = (n == 30) || (n == 100)
                  || (n == 5000);
      s_axis_data = 32'h00FF_FFFF;
      if (n == 1) chk("lat_dout_e1", o_dout, 0);
      if (n == 2) chk("lat_dout_e2", o_dout, 1);
    end while (!o_frame_done && n < 20000);
    s_axis_valid = 1'b0;
    chk("single_frame_len", n, 1440 + 96 + TRST);
    chk("single_ready", s_axis_ready, 1);
    chk("single_busy", o_busy, 0);
    @(negedge clk);
    #1;
    chk("single_done_cnt", n_done - d0, 1);

    // Eight words, one frame; last taken at GAP cnt=95
    @(posedge clk);
    #1;
    d0 = n_done;
    send_word(words[0]);
    for (int k = 1; k < 8; k++) begin
      wait_ready(3000);
      if (k == 7) repeat (95) @(posedge clk);
      else @(posedge clk);
      #1;
      send_word(words[k]);
      if (k == 7) begin
        @(posedge clk);
        #1;
        chk("gap95_dout_e1", o_dout, 0);
        @(posedge clk);
        #1;
        chk("gap95_dout_e2", o_dout, 1);
      end
    end
    wait_done(20000, n, sr, pb);
    @(negedge clk);
    #1;
    chk("multi_done_cnt", n_done - d0, 1);
    chk("multi_bits_left", exp_q.size(), 0);

    // Reset in the middle of bit 10
    @(posedge clk);
    #1;
    send_word(32'h00AB_CDEF);
    repeat (784) @(posedge clk);
    #1;
    chk("mid_dout_high", o_dout, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_dout_drop", o_dout, 0);
    chk("mid_ready", s_axis_ready, 0);
    rst_n = 1'b1;
    wait_done(20000, n, sr, pb);
    chk("mid_latch_len", n, TRST);
    chk("mid_early_ready", sr, 0);
    chk("mid_ready_after", s_axis_ready, 1);

    // Next word restarts from bit 23
    send_word(32'h0080_0001);
    wait_ready(3000);
    @(negedge clk);
    #1;
    chk("final_bits_left", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
